seg_display: RTL and testbench
==============================

SEG_DISPLAY -- requirements
Module: seg_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000: clk cycles each digit is driven (250 Hz per digit at 100 MHz).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000: clk cycles per blink half-period.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port minutes  input  6  binary minutes, 0-63 accepted.
REQ-006 SHALL have port seconds  input  6  binary seconds, 0-63 accepted.
REQ-007 SHALL have port adj  input  1  adjust mode; 1 enables blinking of the selected field.
REQ-008 SHALL have port sel  input  1  field select in adjust mode: 1 = seconds, 0 = minutes.
REQ-009 SHALL have port seg  output  8  active-low segments: [7] = dp, [6:0] = g..a.
REQ-010 SHALL have port an  output  4  active-low digit enables: [3] min tens, [2] min ones, [1] sec tens, [0] sec ones.

Function
REQ-011 SHALL run scan_cnt from 0 to SCAN_DIV-1 and wrap; the wrap cycle is the scan tick.
REQ-012 SHALL advance digit index 0->1->2->3->0 on each scan tick; index k drives an[k].
REQ-013 SHALL register seg/an from the current index and snapshot, so outputs lag the index by exactly 1 cycle.
REQ-014 SHALL capture minutes/seconds into snapshot registers on a scan tick with index 3; the frame starting at index 0 uses only that snapshot (no mid-frame tearing).
REQ-015 SHALL split each snapshot into tens = value/10 and ones = value%10; 60-63 display as tens 6, ones 0-3.
REQ-016 SHALL decode digits 0-9 to the standard active-low pattern; only one an bit is low at a time.
REQ-017 SHALL drive dp low (lit) only on index 2 as the min:sec separator; dp high otherwise.
REQ-018 SHALL toggle blink_on every BLINK_DIV cycles.
REQ-019 SHALL force seg = 8'hFF (an unchanged) when adj=1, blink_on=0, and index is in the selected field (sel=1: 0-1; sel=0: 2-3).
REQ-020 SHALL apply adj/sel changes on the next output register update, without resetting blink or scan counters.

Reset
REQ-021 SHALL, while rst=1, set seg=8'hFF, an=4'hF, scan_cnt=0, index=0, blink counter=0, blink_on=1, snapshots=0.
REQ-022 SHALL, on the first cycle after rst falls, drive an=4'b1110 showing snapshot (0).
REQ-023 SHALL give rst priority over every other event, including a scan tick in the same cycle.

Structure
REQ-024 SHALL place the digit-to-segment pattern table, blank pattern 8'hFF and digit count 4 in the team's shared constants package.
REQ-025 SHALL use one combinational sub-module, seg_decoder (4-bit digit -> 7 active-low segments); all state stays in seg_display.

Verification (SCAN_DIV=4, BLINK_DIV=16)
REQ-026 SHALL check reset: rst=1 -> seg=FF, an=F; release -> next cycle an=1110, seg=C0.
REQ-027 SHALL check display: minutes=12, seconds=34 held two frames -> an=0111/F9, 1011/24 (dp lit), 1101/B0, 1110/99, each held 4 cycles.
REQ-028 SHALL check tearing: seconds 34->35 at index 1 -> an=1110 still shows 99 until after the 3->0 wrap, then 92.
REQ-029 SHALL check blink: adj=1, sel=1 -> seg=FF on an=1110/1101 during blink_on=0, minutes digits unaffected; sel=0 -> minutes digits blanked.
REQ-030 SHALL check overrange: minutes=63 -> an=0111 seg=82, an=1011 seg=30.
REQ-031 SHALL check reset mid-frame: rst at index 2 -> next cycle an=F, index 0, blink_on=1.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared constants for the four-digit min:sec display: digit positions,
// segment patterns and the binary-to-BCD helpers used by the scan logic.
package seg_display_pkg;

    localparam int DIGIT_COUNT = 4;

    // Full segment byte including dp; all ones is fully dark (active-low).
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    // Active-low g..a patterns for digits 0-9.
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h40,  // 0
        7'h79,  // 1
        7'h24,  // 2
        7'h30,  // 3
        7'h19,  // 4
        7'h12,  // 5
        7'h02,  // 6
        7'h78,  // 7
        7'h00,  // 8
        7'h10   // 9
    };

    // Scan position; the value is also the bit of an that is driven low.
    typedef enum logic [1:0] {
        DIG_SEC_ONES = 2'd0,
        DIG_SEC_TENS = 2'd1,
        DIG_MIN_ONES = 2'd2,
        DIG_MIN_TENS = 2'd3
    } digit_e;

    function automatic logic [3:0] tens_of(input logic [5:0] v);
        logic [5:0] q;
        q = v / 6'd10;
        return q[3:0];
    endfunction

    function automatic logic [3:0] ones_of(input logic [5:0] v);
        logic [5:0] r;
        r = v % 6'd10;
        return r[3:0];
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD digit to active-low seven-segment (g..a) decoder.
// Codes above 9 leave every segment dark.
module seg_decoder
    import seg_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (digit <= 4'd9) begin
            seg = SEG_TABLE[digit];
        end
    end

endmodule

// File: rtl/seg_display.sv
// Multiplexed four-digit min:sec driver: scans one digit per SCAN_DIV cycles,
// snapshots the time once per frame and blinks the field being adjusted.
module seg_display
    import seg_display_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       adj,
    input  logic       sel,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;
    digit_e             idx;
    logic [5:0]         min_snap;
    logic [5:0]         sec_snap;

    logic               scan_tick;
    logic               blink_tick;
    logic [3:0]         digit;
    logic [6:0]         seg_raw;
    logic               in_field;
    logic               blank;
    logic [7:0]         seg_next;
    logic [3:0]         an_next;

    assign scan_tick  = (scan_cnt  == SCAN_W'(SCAN_DIV - 1));
    assign blink_tick = (blink_cnt == BLINK_W'(BLINK_DIV - 1));

    // Value shown at the current scan position, taken only from the snapshot.
    always_comb begin
        digit = 4'd0;
        case (idx)
            DIG_SEC_ONES: digit = ones_of(sec_snap);
            DIG_SEC_TENS: digit = tens_of(sec_snap);
            DIG_MIN_ONES: digit = ones_of(min_snap);
            DIG_MIN_TENS: digit = tens_of(min_snap);
            default:      digit = 4'd0;
        endcase
    end

    seg_decoder u_decoder (
        .digit (digit),
        .seg   (seg_raw)
    );

    always_comb begin
        in_field = 1'b0;
        if (sel) begin
            in_field = (idx == DIG_SEC_ONES) || (idx == DIG_SEC_TENS);
        end else begin
            in_field = (idx == DIG_MIN_ONES) || (idx == DIG_MIN_TENS);
        end
        blank = adj && !blink_on && in_field;

        // dp on the minutes-ones digit forms the colon between min and sec.
        seg_next = {(idx != DIG_MIN_ONES), seg_raw};
        if (blank) begin
            seg_next = SEG_BLANK;
        end
        an_next = ~(4'b0001 << idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            idx       <= DIG_SEC_ONES;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            min_snap  <= 6'd0;
            sec_snap  <= 6'd0;
            seg       <= SEG_BLANK;
            an        <= 4'hF;
        end else begin
            seg <= seg_next;
            an  <= an_next;

            if (scan_tick) begin
                scan_cnt <= '0;
                idx      <= digit_e'(idx + 2'd1);
                // Capturing on the last digit makes the next frame consistent.
                if (idx == DIG_MIN_TENS) begin
                    min_snap <= minutes;
                    sec_snap <= seconds;
                end
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end

            if (blink_tick) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg_display.sv
// Directed bench for seg_display with a short scan (4) and blink (16) period;
// every step's an/seg value is hand-derived from the cycle count since reset.
module tb_seg_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       adj;
    logic       sel;
    logic [7:0] seg;
    logic [3:0] an;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    seg_display #(
        .SCAN_DIV  (4),
        .BLINK_DIV (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .minutes (minutes),
        .seconds (seconds),
        .adj     (adj),
        .sel     (sel),
        .seg     (seg),
        .an      (an)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] an_e, input logic [7:0] seg_e);
        tests_run++;
        assert (an === an_e && seg === seg_e) else begin
            tests_failed++;
            $error("FAIL %s: an=%b seg=%h, expected an=%b seg=%h", tag, an, seg, an_e, seg_e);
        end
    endtask

    // Advance n cycles, checking the registered outputs after each edge.
    task automatic hold(input string tag, input logic [3:0] an_e, input logic [7:0] seg_e,
                        input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check(tag, an_e, seg_e);
        end
    endtask

    initial begin
        rst     = 1'b1;
        minutes = 6'd12;
        seconds = 6'd34;
        adj     = 1'b0;
        sel     = 1'b0;
        step();
        step();
        step();
        check("reset", 4'hF, 8'hFF);

        rst = 1'b0;
        hold("release", 4'b1110, 8'hC0, 1);

        // Frame from the zero snapshot, then two frames of 12:34.
        hold("zero_d0", 4'b1110, 8'hC0, 3);
        hold("zero_d1", 4'b1101, 8'hC0, 4);
        hold("zero_d2", 4'b1011, 8'h40, 4);
        hold("zero_d3", 4'b0111, 8'hC0, 4);
        for (int f = 0; f < 2; f++) begin
            hold("disp_sec1", 4'b1110, 8'h99, 4);
            hold("disp_sec10", 4'b1101, 8'hB0, 4);
            hold("disp_min1", 4'b1011, 8'h24, 4);
            hold("disp_min10", 4'b0111, 8'hF9, 4);
        end

        // Seconds change at index 1: ones digit keeps 4 until the next frame.
        hold("tear_sec1", 4'b1110, 8'h99, 4);
        hold("tear_sec10", 4'b1101, 8'hB0, 1);
        seconds = 6'd35;
        hold("tear_sec10", 4'b1101, 8'hB0, 3);
        hold("tear_min1", 4'b1011, 8'h24, 4);
        hold("tear_min10", 4'b0111, 8'hF9, 4);
        hold("tear_new_sec1", 4'b1110, 8'h92, 4);

        // Minutes change at index 1: later digits of this frame keep 12.
        hold("tear2_sec10", 4'b1101, 8'hB0, 1);
        minutes = 6'd63;
        hold("tear2_sec10", 4'b1101, 8'hB0, 3);
        hold("tear2_min1", 4'b1011, 8'h24, 4);
        hold("tear2_min10", 4'b0111, 8'hF9, 4);

        // 63 decodes as tens 6, ones 3.
        hold("over_sec1", 4'b1110, 8'h92, 4);
        hold("over_sec10", 4'b1101, 8'hB0, 4);
        hold("over_min1", 4'b1011, 8'h30, 4);
        hold("over_min10", 4'b0111, 8'h82, 4);

        // Adjust seconds while blink_on=1: nothing blanked.
        adj = 1'b1;
        sel = 1'b1;
        hold("blink_on_sec1", 4'b1110, 8'h92, 4);
        hold("blink_on_sec10", 4'b1101, 8'hB0, 4);
        hold("blink_on_min1", 4'b1011, 8'h30, 4);
        hold("blink_on_min10", 4'b0111, 8'h82, 4);

        // blink_on=0: seconds field dark, then sel flips mid-digit.
        hold("blink_sec1_off", 4'b1110, 8'hFF, 2);
        sel = 1'b0;
        hold("blink_sel_min_sec1", 4'b1110, 8'h92, 2);
        hold("blink_sel_min_sec10", 4'b1101, 8'hB0, 4);
        hold("blink_min1_off", 4'b1011, 8'hFF, 4);
        hold("blink_min10_off", 4'b0111, 8'hFF, 4);

        // Reset asserted while index 2 is displayed.
        adj = 1'b0;
        hold("pre_rst_sec1", 4'b1110, 8'h92, 4);
        hold("pre_rst_sec10", 4'b1101, 8'hB0, 4);
        hold("pre_rst_min1", 4'b1011, 8'h30, 1);
        rst = 1'b1;
        adj = 1'b1;
        sel = 1'b1;
        hold("rst_mid", 4'hF, 8'hFF, 1);
        rst = 1'b0;

        // Index restarts at 0, snapshots are 0, blink_on restarts at 1.
        hold("post_rst_sec1", 4'b1110, 8'hC0, 4);
        hold("post_rst_sec10", 4'b1101, 8'hC0, 4);
        hold("post_rst_min1", 4'b1011, 8'h40, 4);
        hold("post_rst_min10", 4'b0111, 8'hC0, 4);
        hold("post_rst_blink_sec1", 4'b1110, 8'hFF, 4);
        hold("post_rst_blink_sec10", 4'b1101, 8'hFF, 4);
        hold("post_rst_min1_63", 4'b1011, 8'h30, 4);
        hold("post_rst_min10_63", 4'b0111, 8'h82, 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
